hub75_rx: RTL
=============

Name: hub75_rx

Overview:
- Receiving end of the HUB75 LED-matrix interface: behaves like one panel's column shift registers, output latches and row decoder.
- Samples the six colour lines on rising panel-clock edges and captures a row on each latch pulse.
- Streams the latched row out as a sequence of framebuffer writes.
- Used in loopback tests of our HUB75 drivers, and as the front end of a panel-sniffer / chaining bridge.

Parameters:
- COLS, 64, columns shifted per row; legal range 2..256.
- COL_BITS, 6, width of column index; must satisfy 2^COL_BITS >= COLS.
- ADDR_BITS, 5, number of row-address lines (A..E).

Ports:
- clk  in  1  system clock (27 MHz on the board).
- rst  in  1  synchronous, active-high reset.
- h75_clk  in  1  panel shift clock from the driver.
- h75_lat  in  1  panel latch strobe.
- h75_oe  in  1  panel output enable, active low.
- h75_addr  in  ADDR_BITS  row address, bit 0 = A.
- h75_rgb  in  6  colour data {B2,G2,R2,B1,G1,R1}.
- wr_en  out  1  framebuffer write strobe.
- wr_row  out  ADDR_BITS  row of the current write.
- wr_col  out  COL_BITS  column of the current write.
- wr_data  out  6  pixel bits {B2,G2,R2,B1,G1,R1}.
- display_on  out  1  synchronised inverse of h75_oe.
- err_short  out  1  sticky: latch arrived with fewer than COLS shifts.
- err_long  out  1  sticky: more than COLS shifts before a latch.
- err_overrun  out  1  sticky: latch arrived during a dump.
- err_clr  in  1  clears all sticky error flags.

Behaviour:
- Single clock domain `clk`. Reset is synchronous and active-high on `rst`; all flops clear on it.
- Input synchronisation:
  - All h75_* inputs pass through a 2-flop synchroniser, then one "previous" register.
  - rise_clk = sync2 & ~prev for h75_clk; rise_lat is formed the same way for h75_lat.
  - Data and address are taken from the sync2 stage, so they stay aligned with the edge.
- Shift path, on each rise_clk:
  - The 6xCOLS shift register shifts by one; the first column shifted in ends up at column 0 after COLS shifts.
  - col_cnt increments, saturating at COLS.
  - A rise_clk while col_cnt == COLS sets err_long; the shift still occurs and the oldest column is dropped.
- Latch, on rise_lat:
  - Shift register is copied into row_buf; sync2 address is captured into wr_row.
  - If col_cnt != COLS, err_short is set.
  - col_cnt clears to 0.
  - FSM enters DUMP with dump_col = 0.
- If rise_clk and rise_lat occur in the same cycle: the shift completes first, the latch then copies the shifted contents, and col_cnt becomes 0.
- FSM states: IDLE, DUMP.
  - IDLE -> DUMP on rise_lat.
  - In DUMP, each cycle: wr_en = 1, wr_col = dump_col, wr_data = row_buf[dump_col], then dump_col increments.
  - DUMP -> IDLE after the cycle with dump_col == COLS-1; exactly COLS consecutive writes are produced.
  - rise_lat during DUMP: err_overrun is set, row_buf and wr_row are reloaded, and dump_col restarts at 0; there is no gap in wr_en.
- Latency: first wr_en occurs 3 clk cycles after the clk edge at which h75_lat is first sampled high.
- Outputs are registered. wr_row, wr_col and wr_data hold their last values while in IDLE.
- display_on = ~sync2(h75_oe). It is informational only and does not gate writes.
- Error flags:
  - err_clr clears all flags.
  - If err_clr and a flag's set condition occur in the same cycle, set wins.
- Reset values: wr_en 0, wr_row 0, wr_col 0, wr_data 0, display_on 0, all err_* flags 0, FSM IDLE, col_cnt 0.
- Reset mid-dump aborts the dump immediately; no further writes occur.
- Timing requirement: the panel clock must be no faster than clk/4, with each level held at least 2 clk cycles. Our driver at 1 MHz with a 27 MHz clk satisfies this.

Optional Feature:
HUB75_RX_FRAME_CNT_EN
- Defined: adds output frame_cnt [15:0] (reset 0).
  - Increments on every rise_lat whose captured address is 0 and whose previous captured address was 2^ADDR_BITS-1.
  - Wraps from 0xFFFF to 0.
- Undefined: no frame_cnt port, no address-history register.

Test Plan:
- Reset, then 64 panel-clock pulses with h75_rgb = column index[5:0] and addr = 5, then a latch -> 64 consecutive writes, wr_row = 5, wr_col 0..63, wr_data = wr_col; all err_* flags stay 0.
- 60 shifts then latch -> err_short = 1 and 64 writes still produced; pulse err_clr -> err_short = 0.
- 66 shifts with data = i, then latch -> err_long = 1 and column 0 holds 2 (the two oldest columns dropped).
- Second latch 20 cycles into a dump -> err_overrun = 1, wr_col restarts at 0, wr_en continuous for 84 cycles total.
- Assert rst at dump cycle 10 -> wr_en = 0 on the next cycle, all flags 0, FSM IDLE.
- (HUB75_RX_FRAME_CNT_EN) Latch rows 0..31 then row 0 -> frame_cnt steps 0 -> 1; a repeated latch of row 0 leaves it at 1.

Source files
------------

// File: rtl/hub75_rx.sv
// HUB75 panel receiver: column shift register, row latch and framebuffer write streamer.
// Optional `HUB75_RX_FRAME_CNT_EN adds a frame_cnt output counting row-31 -> row-0 latch wraps.
module hub75_rx #(
  parameter int COLS      = 64,
  parameter int COL_BITS  = 6,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 h75_clk,
  input  logic                 h75_lat,
  input  logic                 h75_oe,
  input  logic [ADDR_BITS-1:0] h75_addr,
  input  logic [5:0]           h75_rgb,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_row,
  output logic [COL_BITS-1:0]  wr_col,
  output logic [5:0]           wr_data,
  output logic                 display_on,
  output logic                 err_short,
  output logic                 err_long,
  output logic                 err_overrun,
  input  logic                 err_clr
`ifdef HUB75_RX_FRAME_CNT_EN
  ,
  output logic [15:0]          frame_cnt
`endif
);

  localparam int CNT_W = COL_BITS + 1;

  typedef enum logic {IDLE, DUMP} state_t;

  logic                 clk_p0, clk_p1, clk_p2;
  logic                 lat_p0, lat_p1, lat_p2;
  logic                 oe_p0, oe_p1;
  logic [ADDR_BITS-1:0] addr_p0, addr_p1;
  logic [5:0]           rgb_p0, rgb_p1;

  logic                 rise_clk, rise_lat;
  logic [5:0]           sr      [COLS];
  logic [5:0]           sr_nxt  [COLS];
  logic [5:0]           row_buf [COLS];
  logic [CNT_W-1:0]     col_cnt, col_cnt_nxt;
  logic [COL_BITS-1:0]  dump_col;
  state_t               state;

  // Stage p0/p1: two-flop synchroniser; p2: previous value for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_p0  <= 1'b0; clk_p1 <= 1'b0; clk_p2 <= 1'b0;
      lat_p0  <= 1'b0; lat_p1 <= 1'b0; lat_p2 <= 1'b0;
      oe_p0   <= 1'b0; oe_p1  <= 1'b0;
      addr_p0 <= '0;   addr_p1 <= '0;
      rgb_p0  <= '0;   rgb_p1  <= '0;
    end else begin
      clk_p0  <= h75_clk;  clk_p1  <= clk_p0;  clk_p2 <= clk_p1;
      lat_p0  <= h75_lat;  lat_p1  <= lat_p0;  lat_p2 <= lat_p1;
      oe_p0   <= h75_oe;   oe_p1   <= oe_p0;
      addr_p0 <= h75_addr; addr_p1 <= addr_p0;
      rgb_p0  <= h75_rgb;  rgb_p1  <= rgb_p0;
    end
  end

  assign rise_clk = clk_p1 & ~clk_p2;
  assign rise_lat = lat_p1 & ~lat_p2;

  // Shift happens before a coincident latch, so the latch sees the post-shift contents
  always_comb begin
    for (int i = 0; i < COLS; i++) sr_nxt[i] = sr[i];
    col_cnt_nxt = col_cnt;
    if (rise_clk) begin
      for (int i = 0; i < COLS - 1; i++) sr_nxt[i] = sr[i+1];
      sr_nxt[COLS-1] = rgb_p1;
      if (col_cnt != CNT_W'(COLS)) col_cnt_nxt = col_cnt + 1'b1;
    end
  end

  // Stage: shift register, row latch, dump FSM and registered write outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < COLS; i++) begin
        sr[i]      <= '0;
        row_buf[i] <= '0;
      end
      col_cnt     <= '0;
      dump_col    <= '0;
      state       <= IDLE;
      wr_en       <= 1'b0;
      wr_row      <= '0;
      wr_col      <= '0;
      wr_data     <= '0;
      display_on  <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      for (int i = 0; i < COLS; i++) sr[i] <= sr_nxt[i];
      col_cnt    <= rise_lat ? '0 : col_cnt_nxt;
      display_on <= ~oe_p1;

      // Set has priority over clear
      err_long    <= (err_long & ~err_clr) | (rise_clk & (col_cnt == CNT_W'(COLS)));
      err_short   <= (err_short & ~err_clr) | (rise_lat & (col_cnt_nxt != CNT_W'(COLS)));
      err_overrun <= (err_overrun & ~err_clr) | (rise_lat & (state == DUMP));

      wr_en <= (state == DUMP);
      if (state == DUMP) begin
        wr_col  <= dump_col;
        wr_data <= row_buf[dump_col];
      end

      if (rise_lat) begin
        for (int i = 0; i < COLS; i++) row_buf[i] <= sr_nxt[i];
        wr_row   <= addr_p1;
        dump_col <= '0;
        state    <= DUMP;
      end else if (state == DUMP) begin
        if (dump_col == COL_BITS'(COLS - 1)) begin
          dump_col <= '0;
          state    <= IDLE;
        end else begin
          dump_col <= dump_col + 1'b1;
        end
      end
    end
  end

`ifdef HUB75_RX_FRAME_CNT_EN
  logic [ADDR_BITS-1:0] addr_hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_hist <= '0;
      frame_cnt <= '0;
    end else if (rise_lat) begin
      addr_hist <= addr_p1;
      if ((addr_p1 == '0) && (addr_hist == '1)) frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule
